sm_trace_fifo: RTL and testbench
================================

// Module: sm_trace_fifo
// PURPOSE
//  Retire-trace capture stage fed directly by sm_cpu.
//  Samples pc, instr and a0 (rf[10]) on every enabled CPU cycle and records them, tagged with a cycle number, in a FIFO.
//  Detects a self-loop halt and a cycle-budget timeout, then freezes capture.
//  A downstream reader drains entries over a valid/ready port: debug UART, LED display or bench monitor.
// PARAMETERS
//  DEPTH        16   FIFO entries; power of 2, >= 2
//  CYC_W        16   width of cycle tag; wraps modulo 2^CYC_W
//  HALT_REPEAT  4    consecutive identical-pc captures that declare halt; >= 2
//  MAX_CYCLES   120  captures before timeout; >= 1
// PORTS
//  clk        in   1              single clock; all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  cpu_en     in   1              CPU clock enable; one instruction retires per enabled cycle
//  cpu_pc     in   32             pc of the retiring instruction
//  cpu_instr  in   32             instruction word at cpu_pc
//  cpu_a0     in   32             current value of register a0
//  rd_valid   out  1              head entry available
//  rd_ready   in   1              reader accepts head entry
//  rd_cycle   out  CYC_W          head entry cycle tag
//  rd_pc      out  32             head entry pc
//  rd_instr   out  32             head entry instruction
//  rd_a0      out  32             head entry a0
//  level      out  clog2(DEPTH)+1 entries currently stored
//  overflow   out  1              sticky; set when any capture was dropped
//  drop_cnt   out  8              dropped captures; saturates at 255
//  halted     out  1              sticky; self-loop detected
//  timeout    out  1              sticky; MAX_CYCLES captures reached
// BEHAVIOUR
//  Reset:
//   - All outputs 0.
//   - FIFO emptied; cycle counter, repeat counter and last-pc register cleared.
//   - rst asserted mid-run discards all content and flags on the same edge.
//  Capture:
//   - A capture occurs at a posedge with cpu_en=1 && !halted && !timeout && !rst.
//   - cpu_en=0 cycles neither capture nor advance the cycle counter.
//  Cycle tag:
//   - Entry tag = number of earlier captures since reset, mod 2^CYC_W. The first capture has tag 0.
//  Push:
//   - If the FIFO is not full (or is full and a pop occurs on the same edge), the entry is written.
//   - Otherwise the entry is dropped: overflow<=1, drop_cnt increments (saturating at 255).
//   - The cycle counter advances on drops as well.
//  Pop and read port:
//   - Pop occurs when rd_valid && rd_ready. rd_valid = (level != 0).
//   - Read port is first-word-fall-through: rd_* show the head entry combinationally from storage.
//   - After reset, rd_* read 0. When empty, rd_* hold the last popped entry.
//  Latency:
//   - An entry captured at edge N is on rd_* with rd_valid=1 from edge N onward (one cycle after sampling).
//   - No same-cycle bypass: on an empty FIFO, push and pop on one edge is impossible because rd_valid=0.
//  Simultaneous push+pop:
//   - level is unchanged and nothing is dropped, including when full.
//  Pointers:
//   - clog2(DEPTH)-bit read/write pointers wrap naturally.
//   - level = write count - read count, range 0..DEPTH.
//  Halt:
//   - Track rep: rep=1 on any capture whose pc differs from the last captured pc; rep increments when the pc is equal.
//   - The first capture after reset has rep=1.
//   - When a capture makes rep==HALT_REPEAT, that capture is still pushed, and halted<=1 on the same edge.
//  Timeout:
//   - On the capture whose tag == MAX_CYCLES-1, the entry is pushed and timeout<=1 on that edge.
//   - Halt and timeout may assert on the same edge; both are set.
//  Freeze:
//   - After halted or timeout, the FIFO still drains normally. Only rst clears the flags.
// TESTING
//  1. rst, then cpu_en=1, pc=0,4,8, rd_ready=0 -> level=3, rd_pc=0, rd_cycle=0. Then rd_ready=1 for 3 cycles -> pops (0,0),(4,1),(8,2); level=0, rd_valid=0.
//  2. DEPTH=16, 20 distinct-pc captures, no reads -> level=16, overflow=1, drop_cnt=4; popped tags 0..15. A following capture gets tag 20.
//  3. FIFO full, cpu_en=1 and rd_ready=1 on the same cycle -> level stays 16, drop_cnt unchanged, new entry appears at the tail.
//  4. pc=0,4,8,8,8,8 (HALT_REPEAT=4) -> halted=1 after 6th capture, level=6; further cpu_en cycles with pc=8 -> level stays 6, no drops.
//  5. MAX_CYCLES=10, distinct pcs, cpu_en toggling 1/0 -> timeout=1 after the 10th enabled cycle, level=10, last tag 9; disabled cycles add no tags.
//  6. level=5 with halted=1, pulse rst for 1 cycle -> next cycle: rd_valid=0, level=0, halted=0, overflow=0, rd_*=0. The next capture gets tag 0.

Source files
------------

// File: rtl/sm_trace_fifo.sv
// Retire-trace capture FIFO behind sm_cpu: tags each enabled retirement with a cycle number,
// stops capturing on a self-loop halt or cycle-budget timeout, and drains over valid/ready.
module sm_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter int CYC_W       = 16,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 120
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_en,
    input  logic [31:0]              cpu_pc,
    input  logic [31:0]              cpu_instr,
    input  logic [31:0]              cpu_a0,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [31:0]              rd_a0,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     halted,
    output logic                     timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [PW:0]      LVL_FULL = (PW + 1)'(DEPTH);
    localparam logic [RW-1:0]    REP_HALT = RW'(HALT_REPEAT);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

    logic [CYC_W-1:0] memCycle [DEPTH];
    logic [31:0]      memPc    [DEPTH];
    logic [31:0]      memInstr [DEPTH];
    logic [31:0]      memA0    [DEPTH];

    logic [PW-1:0]    wrPtr, rdPtr;
    logic [CYC_W-1:0] cycCnt;
    logic [RW-1:0]    repCnt, nextRep;
    logic [31:0]      lastPc;
    logic [CYC_W-1:0] holdCycle;
    logic [31:0]      holdPc, holdInstr, holdA0;
    logic             capture, pop, push;

    assign rd_valid = (level != '0);
    assign capture  = cpu_en && !halted && !timeout;
    assign pop      = rd_valid && rd_ready;
    assign push     = capture && ((level != LVL_FULL) || pop);
    // lastPc resets to 0, so repCnt=0 makes the first capture land on 1 whatever its pc
    assign nextRep  = (cpu_pc == lastPc) ? repCnt + 1'b1 : RW'(1);

    // Head comes straight from storage; once empty, show the entry most recently popped.
    assign rd_cycle = rd_valid ? memCycle[rdPtr] : holdCycle;
    assign rd_pc    = rd_valid ? memPc[rdPtr]    : holdPc;
    assign rd_instr = rd_valid ? memInstr[rdPtr] : holdInstr;
    assign rd_a0    = rd_valid ? memA0[rdPtr]    : holdA0;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            memCycle[wrPtr] <= cycCnt;
            memPc[wrPtr]    <= cpu_pc;
            memInstr[wrPtr] <= cpu_instr;
            memA0[wrPtr]    <= cpu_a0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            cycCnt    <= '0;
            repCnt    <= '0;
            lastPc    <= '0;
            holdCycle <= '0;
            holdPc    <= '0;
            holdInstr <= '0;
            holdA0    <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (pop) begin
                rdPtr     <= rdPtr + 1'b1;
                holdCycle <= memCycle[rdPtr];
                holdPc    <= memPc[rdPtr];
                holdInstr <= memInstr[rdPtr];
                holdA0    <= memA0[rdPtr];
            end
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;

            if (capture) begin
                cycCnt <= cycCnt + 1'b1;
                lastPc <= cpu_pc;
                repCnt <= nextRep;
                if (nextRep == REP_HALT)
                    halted <= 1'b1;
                if (cycCnt == CYC_LAST)
                    timeout <= 1'b1;
                if (!push) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_trace_fifo.sv
// Bench for sm_trace_fifo: directed scenarios plus random traffic, all checked against a
// queue-based reference model of capture, tagging, halt/timeout and draining.
module tb_sm_trace_fifo;

    localparam int DEPTH       = 16;
    localparam int CYC_W       = 16;
    localparam int HALT_REPEAT = 4;
    localparam int MAX_CYCLES  = 120;

    logic        clk = 1'b0;
    logic        rst, cpu_en, rd_ready;
    logic [31:0] cpu_pc, cpu_instr, cpu_a0;
    logic        rd_valid;
    logic [15:0] rd_cycle;
    logic [31:0] rd_pc, rd_instr, rd_a0;
    logic [4:0]  level;
    logic        overflow, halted, timeout;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    sm_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W), .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .cpu_a0(cpu_a0), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cycle(rd_cycle),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_a0(rd_a0), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted), .timeout(timeout)
    );

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a0;
    } entry_t;

    entry_t      q[$];
    entry_t      lastPop;
    int          capCount, rep, drops;
    bit          havePrev, mHalt, mTime, mOvf;
    logic [31:0] prevPc;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        lastPop  = '0;
        capCount = 0;
        rep      = 0;
        drops    = 0;
        havePrev = 0;
        prevPc   = '0;
        mHalt    = 0;
        mTime    = 0;
        mOvf     = 0;
    endtask

    // One clock edge of the reference behaviour, given the inputs presented before it.
    task automatic modelEdge();
        bit     doPop, wasFull;
        entry_t e;
        if (rst) begin
            modelReset();
            return;
        end
        doPop   = (q.size() != 0) && rd_ready;
        wasFull = (q.size() == DEPTH);
        if (doPop) lastPop = q.pop_front();
        if (cpu_en && !mHalt && !mTime) begin
            e.cyc   = 16'(capCount % (1 << CYC_W));
            e.pc    = cpu_pc;
            e.instr = cpu_instr;
            e.a0    = cpu_a0;
            if (!wasFull || doPop) q.push_back(e);
            else begin
                mOvf = 1;
                if (drops < 255) drops++;
            end
            rep = (havePrev && cpu_pc == prevPc) ? rep + 1 : 1;
            havePrev = 1;
            prevPc   = cpu_pc;
            if (rep == HALT_REPEAT) mHalt = 1;
            if (capCount == MAX_CYCLES - 1) mTime = 1;
            capCount++;
        end
    endtask

    task automatic compareAll();
        entry_t h;
        h = (q.size() != 0) ? q[0] : lastPop;
        checkVal("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
        checkVal("level",    64'(level),    64'(q.size()));
        checkVal("rd_cycle", 64'(rd_cycle), 64'(h.cyc));
        checkVal("rd_pc",    64'(rd_pc),    64'(h.pc));
        checkVal("rd_instr", 64'(rd_instr), 64'(h.instr));
        checkVal("rd_a0",    64'(rd_a0),    64'(h.a0));
        checkVal("overflow", 64'(overflow), 64'(mOvf));
        checkVal("drop_cnt", 64'(drop_cnt), 64'(drops));
        checkVal("halted",   64'(halted),   64'(mHalt));
        checkVal("timeout",  64'(timeout),  64'(mTime));
    endtask

    task automatic step(input bit r, input bit en, input logic [31:0] pc, input bit rdy);
        rst       = r;
        cpu_en    = en;
        cpu_pc    = pc;
        cpu_instr = pc ^ 32'h1300_0013;
        cpu_a0    = $urandom;
        rd_ready  = rdy;
        modelEdge();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        int enPct, rdyPct, rstPct;
        logic [31:0] pc;
        rst = 1'b1; cpu_en = 1'b0; rd_ready = 1'b0;
        cpu_pc = '0; cpu_instr = '0; cpu_a0 = '0;
        modelReset();
        #2;

        // basic fill and drain
        step(1, 0, 0, 0);
        checkVal("reset_level", 64'(level), 64'd0);
        step(0, 1, 0, 0);
        step(0, 1, 4, 0);
        step(0, 1, 8, 0);
        checkVal("t1_level", 64'(level), 64'd3);
        checkVal("t1_pc", 64'(rd_pc), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        checkVal("t1_empty", 64'(rd_valid), 64'd0);
        checkVal("t1_hold_pc", 64'(rd_pc), 64'd8);

        // overflow, then push+pop while full, then drain
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'(100 + 4 * i), 0);
        checkVal("t2_level", 64'(level), 64'd16);
        checkVal("t2_drops", 64'(drop_cnt), 64'd4);
        step(0, 1, 32'h500, 1);
        checkVal("t3_level", 64'(level), 64'd16);
        checkVal("t3_drops", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
        checkVal("t3_tail_tag", 64'(rd_cycle), 64'd20);

        // self-loop halt
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 1, 4, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8, 0);
        checkVal("t4_halted", 64'(halted), 64'd1);
        checkVal("t4_level", 64'(level), 64'd6);
        for (int i = 0; i < 3; i++) step(0, 1, 8, 0);
        checkVal("t4_frozen", 64'(level), 64'd6);

        // timeout with enable toggling and continuous drain
        step(1, 0, 0, 0);
        for (int i = 0; i < 2 * MAX_CYCLES + 4; i++) step(0, (i % 2) == 0, 32'(i * 4), 1);
        checkVal("t5_timeout", 64'(timeout), 64'd1);
        checkVal("t5_last_tag", 64'(rd_cycle), 64'(MAX_CYCLES - 1));

        // reset mid-run clears everything
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8, 0);
        checkVal("t6_pre", 64'(level), 64'd5);
        step(1, 0, 0, 0);
        checkVal("t6_halted", 64'(halted), 64'd0);
        checkVal("t6_rdpc", 64'(rd_pc), 64'd0);
        step(0, 1, 32'h40, 0);
        checkVal("t6_tag", 64'(rd_cycle), 64'd0);

        // random traffic
        pc = '0;
        enPct = 70; rdyPct = 50; rstPct = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                enPct  = $urandom_range(30, 100);
                rdyPct = $urandom_range(5, 95);
            end
            if ($urandom_range(0, 2) != 0) pc = 32'($urandom_range(0, 5)) * 4;
            step($urandom_range(0, 299) < rstPct, $urandom_range(0, 99) < enPct, pc,
                 $urandom_range(0, 99) < rdyPct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
